// File: rtl/main_memory_ctrl_pkg.sv
// main_memory_ctrl_pkg: shared constants, FSM states and request record for the main-memory side of the bus.
package main_memory_ctrl_pkg;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 16;
    localparam int LINE_WORDS = 4;
    localparam int LATENCY    = 3;
    localparam int MEM_DEPTH  = 1024;

    typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, WDONE} mem_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
    } mem_req_t;
endpackage

// File: rtl/main_memory_ctrl_if.sv
// main_memory_ctrl_if: request, write-back and read-beat bus between cache controller (master) and main memory (slave).
interface main_memory_ctrl_if #(parameter int DATA_W = 32, parameter int ADDR_W = 16);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic              wdata_valid;
    logic [DATA_W-1:0] wdata;
    logic              intervene;
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              rdata_last;
    logic              done;

    modport master (
        output req_valid, req_write, req_addr, wdata_valid, wdata, intervene,
        input  req_ready, rdata_valid, rdata, rdata_last, done
    );
    modport slave (
        input  req_valid, req_write, req_addr, wdata_valid, wdata, intervene,
        output req_ready, rdata_valid, rdata, rdata_last, done
    );
endinterface

// File: rtl/main_memory_ctrl_mem_word_array.sv
// mem_word_array: single-port word RAM, synchronous write and combinational read, contents never reset.
module mem_word_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk)
        if (i_we) r_mem[i_addr] <= i_wdata;

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: serves line fills after a fixed latency and absorbs write-backs beat by beat;
// a snooped Modified holder may cancel a fill while it is still waiting on the array.
module main_memory_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 3,
    parameter int MEM_DEPTH  = 1024
) (
    input logic          i_clk,
    input logic          i_rst_n,
    main_memory_ctrl_if.slave bus
);
    import main_memory_ctrl_pkg::*;

    localparam int LW_W   = $clog2(LINE_WORDS);
    localparam int LAT_W  = $clog2(LATENCY + 1);
    localparam int AW     = $clog2(MEM_DEPTH);
    localparam int WORD_W = ADDR_W - 2;

    mem_state_e               r_state;
    logic [WORD_W-LW_W-1:0]   r_line;
    logic [LW_W-1:0]          r_beat;
    logic [LAT_W-1:0]         r_lat;
    logic                     r_ready;
    logic                     r_rvalid;
    logic                     r_rlast;
    logic                     r_done;
    logic [DATA_W-1:0]        r_rdata;

    mem_req_t                 w_req;
    logic [WORD_W-1:0]        w_word;
    logic [DATA_W-1:0]        w_rd;
    logic                     w_we;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_unused;

    assign w_req    = '{write: bus.req_write, addr: bus.req_addr};
    assign w_accept = bus.req_valid && r_ready;
    // line base has zero offset bits, so base+beat is just the concatenation
    assign w_word   = {r_line, r_beat};
    assign w_last   = r_beat == LW_W'(LINE_WORDS - 1);
    assign w_we     = r_state == WBURST && bus.wdata_valid;
    assign w_unused = ^{w_req.addr[LW_W+1:0], w_word[WORD_W-1:AW]};

    assign bus.req_ready   = r_ready;
    assign bus.rdata_valid = r_rvalid;
    assign bus.rdata       = r_rdata;
    assign bus.rdata_last  = r_rlast;
    assign bus.done        = r_done;

    mem_word_array #(.DEPTH(MEM_DEPTH), .DATA_W(DATA_W)) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_addr  (w_word[AW-1:0]),
        .i_wdata (bus.wdata),
        .o_rdata (w_rd)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_line   <= '0;
            r_beat   <= '0;
            r_lat    <= '0;
            r_ready  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_done   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_ready  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= !w_accept;
                    if (w_accept) begin
                        r_line  <= w_req.addr[ADDR_W-1:LW_W+2];
                        r_beat  <= '0;
                        r_lat   <= LAT_W'(LATENCY - 1);
                        r_state <= w_req.write ? WBURST : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.intervene) r_state <= IDLE;
                    else if (r_lat == '0) begin
                        r_state  <= RBURST;
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_rd;
                        r_beat   <= r_beat + 1'b1;
                    end else r_lat <= r_lat - 1'b1;
                end
                RBURST: begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_rd;
                    r_beat   <= r_beat + 1'b1;
                    r_rlast  <= w_last;
                    r_done   <= w_last;
                    if (w_last) r_state <= IDLE;
                end
                WBURST: begin
                    if (bus.wdata_valid) begin
                        r_beat <= r_beat + 1'b1;
                        r_done <= w_last;
                        if (w_last) r_state <= WDONE;
                    end
                end
                WDONE:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb_main_memory_ctrl: scoreboard bench; expected read beats are queued from a word model when a fill is issued
// and popped by a monitor as beats appear, while request/handshake timing is checked cycle by cycle.
module tb_main_memory_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    main_memory_ctrl_if bus();

    main_memory_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] model [1024];
    logic [31:0] exp_q [$];
    int n_chk = 0;
    int n_bad = 0;
    int n_done = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int widx(input logic [15:0] a, input int i);
        return ((int'(a[15:2]) & ~3) + i) % 1024;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) n_done++;
        if (rst_n && bus.rdata_valid) begin
            if (exp_q.size() == 0) chk("spurious_rdata", 1, 0);
            else chk("rdata", bus.rdata, exp_q.pop_front());
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) return;
        end
        chk("ready_timeout", 0, 1);
    endtask

    // leaves time at 1ns after the accepting edge
    task automatic start(input logic [15:0] a, input logic w);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d [4], input logic gaps);
        start(a, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (gaps && i > 0) begin
                @(posedge clk);
                #1;
            end
            bus.wdata_valid = 1'b1;
            bus.wdata       = d[i];
            model[widx(a, i)] = d[i];
            @(posedge clk);
            #1;
            bus.wdata_valid = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("wr_done", bus.done, j == 0);
            chk("wr_ready", bus.req_ready, j == 2);
        end
    endtask

    task automatic do_read(input logic [15:0] a);
        for (int i = 0; i < 4; i++) exp_q.push_back(model[widx(a, i)]);
        start(a, 1'b0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("rd_ready", bus.req_ready, j == 7);
            chk("rd_valid", bus.rdata_valid, j >= 3 && j <= 6);
            chk("rd_last", bus.rdata_last, j == 6);
            chk("rd_done", bus.done, j == 6);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0;
        bus.wdata_valid = 0; bus.wdata = '0; bus.intervene = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_valid", bus.rdata_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rdata", bus.rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.req_ready, 1);

        do_write(16'h0046, '{32'habcdef12, 32'h1, 32'h2, 32'h3}, 1'b0);
        do_read(16'h0040);

        do_write(16'h0100, '{32'h11110000, 32'h22220001, 32'h33330002, 32'h44440003}, 1'b1);
        do_read(16'h010c);

        // fill cancelled by intervention during the second latency cycle
        d0 = n_done;
        start(16'h0100, 1'b0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("iv_valid", bus.rdata_valid, 0);
            chk("iv_ready", bus.req_ready, j >= 3);
            bus.intervene = (j == 1);
        end
        chk("iv_no_done", n_done, d0);

        // second request held during a fill plus stray write data
        for (int i = 0; i < 4; i++) exp_q.push_back(model[widx(16'h0040, i)]);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h0040;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_addr = 16'h0100;
        bus.wdata_valid = 1'b1; bus.wdata = 32'hdead;
        for (int i = 0; i < 4; i++) exp_q.push_back(model[widx(16'h0100, i)]);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("busy_ready", bus.req_ready, j == 7);
            chk("busy_done", bus.done, j == 6);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("busy2_valid", bus.rdata_valid, j >= 3 && j <= 6);
            chk("busy2_done", bus.done, j == 6);
        end
        bus.wdata_valid = 1'b0;
        do_read(16'h0040);

        // asynchronous reset between edges in the middle of a burst
        for (int i = 0; i < 4; i++) exp_q.push_back(model[widx(16'h0100, i)]);
        start(16'h0100, 1'b0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.rdata_valid, 0);
        chk("arst_last", bus.rdata_last, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_ready", bus.req_ready, 0);
        chk("arst_rdata", bus.rdata, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_no_done", n_done, d0);
        do_read(16'h0100);

        // word MEM_DEPTH+4 aliases word 4
        do_write(16'h1010, '{32'hcafe0004, 32'hcafe0005, 32'hcafe0006, 32'hcafe0007}, 1'b0);
        do_read(16'h0010);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
